// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the two-cache memory bus arbiter.
package mem_bus_pkg;

   localparam int BEATS       = 8;
   localparam int LINE_OFFSET = 6;

   localparam logic [12:0] MEM_READ  = 13'h0001;
   localparam logic [12:0] MEM_WRITE = 13'h0002;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ADDR  = 2'd1;
   localparam logic [1:0] ST_WDATA = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ADDR  = ST_ADDR,
      WDATA = ST_WDATA,
      RESP  = ST_RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-input round-robin picker: on a tie the requester not granted last wins.
module rr_arbiter2
   import mem_bus_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_ic_i,
   input  logic req_dc_i,
   input  logic accept_i,
   output logic valid_o,
   output logic pick_dc_o
);

   owner_t last_q;

   assign valid_o   = req_ic_i | req_dc_i;
   assign pick_dc_o = req_dc_i & (~req_ic_i | (last_q == OWN_IC));

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q <= OWN_IC;
      end else if (accept_i && valid_o) begin
         last_q <= pick_dc_o ? OWN_DC : OWN_IC;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between icache and dcache, one 64-byte line transaction at a time.
//
//   state | meaning
//   IDLE  | pick a requester, latch owner/write/aligned address
//   ADDR  | drive address beat until reqack
//   WDATA | drive dcache writeback beats, one idle cycle between beats
//   RESP  | forward read response beats to the owner
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ic_req_i,
   input  logic [63:0]               ic_addr_i,
   output logic                      ic_grant_o,
   output logic                      ic_resp_valid_o,
   output logic [BUS_DATA_WIDTH-1:0] ic_resp_data_o,
   output logic                      ic_done_o,
   input  logic                      dc_req_i,
   input  logic                      dc_write_i,
   input  logic [63:0]               dc_addr_i,
   input  logic [BUS_DATA_WIDTH-1:0] dc_wdata_i,
   output logic                      dc_wdata_pop_o,
   output logic                      dc_grant_o,
   output logic                      dc_resp_valid_o,
   output logic [BUS_DATA_WIDTH-1:0] dc_resp_data_o,
   output logic                      dc_done_o,
   output logic                      bus_reqcyc_o,
   input  logic                      bus_reqack_i,
   output logic [BUS_DATA_WIDTH-1:0] bus_req_o,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_o,
   input  logic                      bus_respcyc_i,
   output logic                      bus_respack_o,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp_i,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag_i,
   output logic                      tag_err_o
);

   localparam int                       CNT_W      = $clog2(BEATS);
   localparam logic [CNT_W-1:0]         LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [63:0]              ALIGN_MASK = ~((64'd1 << LINE_OFFSET) - 64'd1);
   localparam logic [BUS_TAG_WIDTH-1:0] TAG_RD     = BUS_TAG_WIDTH'(MEM_READ);
   localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR     = BUS_TAG_WIDTH'(MEM_WRITE);

   logic [1:0]       state_q, state_d;
   owner_t           owner_q, owner_d;
   logic             write_q, write_d;
   logic [63:0]      addr_q, addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gap_q, gap_d;
   logic             ic_grant_q, ic_grant_d;
   logic             dc_grant_q, dc_grant_d;
   logic             tag_err_q, tag_err_d;

   logic rr_valid, rr_pick_dc;
   logic in_resp, rd_beat, bad_beat, last_rd, wr_ack;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_ic_i  (ic_req_i),
      .req_dc_i  (dc_req_i),
      .accept_i  (state_q == ST_IDLE),
      .valid_o   (rr_valid),
      .pick_dc_o (rr_pick_dc)
   );

   assign in_resp  = (state_q == ST_RESP);
   assign rd_beat  = in_resp & bus_respcyc_i & (bus_resptag_i == TAG_RD);
   assign bad_beat = in_resp & bus_respcyc_i & (bus_resptag_i != TAG_RD);
   assign last_rd  = rd_beat & (cnt_q == LAST_BEAT);
   // gap_q forces reqcyc low for one cycle after every accepted request beat
   assign wr_ack   = (state_q == ST_WDATA) & ~gap_q & bus_reqack_i;

   always_comb begin
      bus_reqcyc_o = (state_q == ST_ADDR) | ((state_q == ST_WDATA) & ~gap_q);
      bus_req_o    = '0;
      bus_reqtag_o = '0;
      if (state_q == ST_ADDR) begin
         bus_req_o    = BUS_DATA_WIDTH'(addr_q);
         bus_reqtag_o = write_q ? TAG_WR : TAG_RD;
      end else if ((state_q == ST_WDATA) && !gap_q) begin
         bus_req_o    = dc_wdata_i;
         bus_reqtag_o = TAG_WR;
      end
   end

   assign bus_respack_o   = in_resp & bus_respcyc_i;
   assign ic_resp_valid_o = rd_beat & (owner_q == OWN_IC);
   assign dc_resp_valid_o = rd_beat & (owner_q == OWN_DC);
   assign ic_resp_data_o  = ic_resp_valid_o ? bus_resp_i : '0;
   assign dc_resp_data_o  = dc_resp_valid_o ? bus_resp_i : '0;
   assign ic_done_o       = last_rd & (owner_q == OWN_IC);
   assign dc_done_o       = (last_rd & (owner_q == OWN_DC)) | (wr_ack & (cnt_q == LAST_BEAT));
   assign dc_wdata_pop_o  = wr_ack;
   assign ic_grant_o      = ic_grant_q;
   assign dc_grant_o      = dc_grant_q;
   assign tag_err_o       = tag_err_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      write_d    = write_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      gap_d      = 1'b0;
      ic_grant_d = 1'b0;
      dc_grant_d = 1'b0;
      tag_err_d  = tag_err_q | bad_beat;
      case (state_q)
         ST_IDLE: begin
            if (rr_valid) begin
               state_d    = ST_ADDR;
               owner_d    = rr_pick_dc ? OWN_DC : OWN_IC;
               write_d    = rr_pick_dc & dc_write_i;
               addr_d     = (rr_pick_dc ? dc_addr_i : ic_addr_i) & ALIGN_MASK;
               cnt_d      = '0;
               ic_grant_d = ~rr_pick_dc;
               dc_grant_d = rr_pick_dc;
            end
         end
         ST_ADDR: begin
            if (bus_reqack_i) begin
               state_d = write_q ? ST_WDATA : ST_RESP;
               gap_d   = 1'b1;
            end
         end
         ST_WDATA: begin
            if (wr_ack) begin
               cnt_d = cnt_q + 1'b1;
               gap_d = 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            if (rd_beat) begin
               cnt_d = cnt_q + 1'b1;
               if (last_rd) begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IC;
         write_q    <= 1'b0;
         addr_q     <= '0;
         cnt_q      <= '0;
         gap_q      <= 1'b0;
         ic_grant_q <= 1'b0;
         dc_grant_q <= 1'b0;
         tag_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         ic_grant_q <= ic_grant_d;
         dc_grant_q <= dc_grant_d;
         tag_err_q  <= tag_err_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle vector table plus multi-cycle sequences.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ic_req_i, ic_grant_o, ic_resp_valid_o, ic_done_o;
   logic [63:0] ic_addr_i, ic_resp_data_o;
   logic        dc_req_i, dc_write_i, dc_wdata_pop_o, dc_grant_o, dc_resp_valid_o, dc_done_o;
   logic [63:0] dc_addr_i, dc_wdata_i, dc_resp_data_o;
   logic        bus_reqcyc_o, bus_reqack_i, bus_respcyc_i, bus_respack_o, tag_err_o;
   logic [63:0] bus_req_o, bus_resp_i;
   logic [12:0] bus_reqtag_o, bus_resptag_i;

   int checks = 0;
   int errors = 0;
   int pend   = 0;
   int hi_run = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
      .clk(clk), .reset(reset),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_grant_o(ic_grant_o),
      .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o), .ic_done_o(ic_done_o),
      .dc_req_i(dc_req_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
      .dc_wdata_pop_o(dc_wdata_pop_o), .dc_grant_o(dc_grant_o), .dc_resp_valid_o(dc_resp_valid_o),
      .dc_resp_data_o(dc_resp_data_o), .dc_done_o(dc_done_o),
      .bus_reqcyc_o(bus_reqcyc_o), .bus_reqack_i(bus_reqack_i), .bus_req_o(bus_req_o),
      .bus_reqtag_o(bus_reqtag_o), .bus_respcyc_i(bus_respcyc_i), .bus_respack_o(bus_respack_o),
      .bus_resp_i(bus_resp_i), .bus_resptag_i(bus_resptag_i), .tag_err_o(tag_err_o)
   );

   // in  = {ic_req, dc_req, dc_write, reqack, respcyc, bad_tag}
   // exp = {ic_grant, dc_grant, reqcyc, respack, ic_rv, dc_rv, ic_done, dc_done, pop, tag_err}
   typedef struct {
      logic [5:0] in;
      logic [7:0] rdata;
      logic [9:0] exp;
      bit         chk_req;
   } row_t;

   row_t tbl[$];

   function automatic row_t mk(logic [5:0] i, logic [7:0] d, logic [9:0] e, bit c);
      row_t r;
      r.in = i; r.rdata = d; r.exp = e; r.chk_req = c;
      return r;
   endfunction

   function automatic logic [9:0] outv();
      return {ic_grant_o, dc_grant_o, bus_reqcyc_o, bus_respack_o, ic_resp_valid_o,
              dc_resp_valid_o, ic_done_o, dc_done_o, dc_wdata_pop_o, tag_err_o};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      ic_req_i = 0; dc_req_i = 0; dc_write_i = 0; dc_wdata_i = '0;
      bus_reqack_i = 0; bus_respcyc_i = 0; bus_resp_i = '0; bus_resptag_i = MEM_READ;
      pend = 0; hi_run = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      clear_inputs();
      @(negedge clk);
      reset = 1;
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_outs"}, 64'(outv()), 64'd0);
      chk({name, "_req"}, bus_req_o, 64'd0);
      chk({name, "_reqtag"}, 64'(bus_reqtag_o), 64'd0);
      chk({name, "_rdata"}, ic_resp_data_o | dc_resp_data_o, 64'd0);
   endtask

   task automatic apply_row(input int idx, input row_t r);
      @(negedge clk);
      ic_req_i      = r.in[5];
      dc_req_i      = r.in[4];
      dc_write_i    = r.in[3];
      bus_reqack_i  = r.in[2];
      bus_respcyc_i = r.in[1];
      bus_resptag_i = r.in[0] ? MEM_WRITE : MEM_READ;
      bus_resp_i    = 64'(r.rdata);
      #2;
      chk($sformatf("row%0d_outs", idx), 64'(outv()), 64'(r.exp));
      if (r.chk_req) begin
         chk($sformatf("row%0d_addr", idx), bus_req_o, 64'h1200);
         chk($sformatf("row%0d_tag", idx), 64'(bus_reqtag_o), 64'(MEM_READ));
      end
      if (r.exp[5]) chk($sformatf("row%0d_data", idx), ic_resp_data_o, 64'(r.rdata));
   endtask

   // Memory model: acks a request beat after ack_delay cycles of reqcyc, returns 8 read beats.
   task automatic model_cycle(input int ack_delay, input logic [63:0] wdata);
      @(negedge clk);
      #1;
      dc_wdata_i    = wdata;
      bus_reqack_i  = bus_reqcyc_o && (hi_run >= ack_delay);
      bus_respcyc_i = (pend > 0);
      bus_resp_i    = 64'(8 - pend);
      bus_resptag_i = MEM_READ;
      #1;
      if (bus_reqcyc_o && bus_reqack_i && bus_reqtag_o == MEM_READ) pend = 8;
      if (bus_respcyc_i && bus_respack_o) pend--;
      hi_run = (bus_reqcyc_o && !bus_reqack_i) ? hi_run + 1 : 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0;
      clear_inputs();
      ic_addr_i = 64'h1234;
      dc_addr_i = '0;
      do_reset();
      #2;
      check_all_zero("reset");

      // icache read, then a second read with a MEM_WRITE-tagged beat injected
      tbl.push_back(mk(6'b100000, 8'd0, 10'b0000000000, 0));
      tbl.push_back(mk(6'b000000, 8'd0, 10'b1010000000, 1));
      tbl.push_back(mk(6'b000000, 8'd0, 10'b0010000000, 1));
      tbl.push_back(mk(6'b000100, 8'd0, 10'b0010000000, 1));
      for (int k = 0; k < 8; k++) begin
         if (k == 2) tbl.push_back(mk(6'b000000, 8'd0, 10'b0000000000, 0));
         tbl.push_back(mk(6'b000010, 8'(k), (k == 7) ? 10'b0001101000 : 10'b0001100000, 0));
      end
      tbl.push_back(mk(6'b000000, 8'd0, 10'b0000000000, 0));
      tbl.push_back(mk(6'b100000, 8'd0, 10'b0000000000, 0));
      tbl.push_back(mk(6'b000100, 8'd0, 10'b1010000000, 1));
      for (int k = 0; k < 8; k++) begin
         if (k == 4) tbl.push_back(mk(6'b000011, 8'hEE, 10'b0001000000, 0));
         tbl.push_back(mk(6'b000010, 8'(16 + k),
                          10'b0001100000 | ((k == 7) ? 10'b0000001000 : 10'b0)
                                         | ((k >= 4) ? 10'b0000000001 : 10'b0), 0));
      end
      tbl.push_back(mk(6'b000000, 8'd0, 10'b0000000001, 0));
      foreach (tbl[i]) apply_row(i, tbl[i]);

      // dcache writeback
      begin
         int pops = 0, dones = 0, grants = 0, rises = 0, beat = 0, resp_seen = 0;
         bit addr_seen = 0, done_ok = 0, prev_rc = 0;
         do_reset();
         dc_addr_i = 64'h8040; dc_write_i = 1; dc_req_i = 1;
         for (int c = 0; c < 40; c++) begin
            model_cycle(1, 64'hA0 + 64'(pops));
            dc_req_i = 0;
            if (dc_grant_o) grants++;
            if (bus_reqcyc_o && !prev_rc) rises++;
            prev_rc = bus_reqcyc_o;
            if (bus_reqcyc_o && bus_reqack_i) begin
               if (!addr_seen) begin
                  chk("wb_addr", bus_req_o, 64'h8040);
                  addr_seen = 1;
               end else begin
                  chk($sformatf("wb_data%0d", beat), bus_req_o, 64'hA0 + 64'(beat));
                  beat++;
               end
               chk("wb_tag", 64'(bus_reqtag_o), 64'(MEM_WRITE));
            end
            if (dc_wdata_pop_o) pops++;
            if (dc_done_o) begin
               dones++;
               done_ok = (pops == 8);
            end
            if (bus_respack_o || ic_resp_valid_o || dc_resp_valid_o) resp_seen++;
         end
         chk("wb_pops", 64'(pops), 64'd8);
         chk("wb_dones", 64'(dones), 64'd1);
         chk("wb_done_on_last", 64'(done_ok), 64'd1);
         chk("wb_grants", 64'(grants), 64'd1);
         chk("wb_reqcyc_beats", 64'(rises), 64'd9);
         chk("wb_no_resp", 64'(resp_seen), 64'd0);
         chk("wb_idle_after", 64'(bus_reqcyc_o), 64'd0);
      end

      // round-robin with both caches requesting continuously
      begin
         int order[$];
         int gcyc[$];
         int dcyc[$];
         int bad_route = 0;
         int cur = -1;
         do_reset();
         dc_write_i = 0; ic_addr_i = 64'h1234; dc_addr_i = 64'h5678;
         ic_req_i = 1; dc_req_i = 1;
         for (int c = 0; c < 200 && dcyc.size() < 4; c++) begin
            model_cycle(0, 64'd0);
            if (ic_grant_o) begin order.push_back(0); gcyc.push_back(c); cur = 0; end
            if (dc_grant_o) begin order.push_back(1); gcyc.push_back(c); cur = 1; end
            if (ic_done_o || dc_done_o) dcyc.push_back(c);
            if ((cur == 1 && ic_resp_valid_o) || (cur == 0 && dc_resp_valid_o)) bad_route++;
         end
         chk("rr_grant_count", 64'(order.size()), 64'd4);
         chk("rr_done_count", 64'(dcyc.size()), 64'd4);
         if (order.size() >= 4) begin
            chk("rr_order0", 64'(order[0]), 64'd1);
            chk("rr_order1", 64'(order[1]), 64'd0);
            chk("rr_order2", 64'(order[2]), 64'd1);
            chk("rr_order3", 64'(order[3]), 64'd0);
         end
         if (gcyc.size() >= 4 && dcyc.size() >= 3) begin
            for (int i = 1; i < 4; i++)
               chk($sformatf("rr_gap%0d", i), 64'(gcyc[i] - dcyc[i-1]), 64'd2);
         end
         chk("rr_routing", 64'(bad_route), 64'd0);
      end

      // reset in the middle of a dcache read
      begin
         int acks = 0, dones = 0;
         do_reset();
         dc_write_i = 0; dc_addr_i = 64'h9000; dc_req_i = 1;
         for (int c = 0; c < 40 && acks < 3; c++) begin
            model_cycle(0, 64'd0);
            if (dc_grant_o) dc_req_i = 0;
            if (bus_respack_o) acks++;
            if (dc_done_o) dones++;
         end
         chk("mr_beats_before_reset", 64'(acks), 64'd3);
         @(negedge clk);
         reset = 0;
         bus_respcyc_i = 1; bus_resptag_i = MEM_READ; bus_resp_i = 64'd3;
         #2;
         if (dc_done_o) dones++;
         @(negedge clk);
         reset = 1;
         ic_req_i = 1;
         #2;
         check_all_zero("mr_after_reset");
         @(negedge clk);
         ic_req_i = 0; bus_respcyc_i = 0;
         #2;
         chk("mr_ic_grant", 64'(ic_grant_o), 64'd1);
         chk("mr_dc_grant", 64'(dc_grant_o), 64'd0);
         chk("mr_no_done", 64'(dones), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus (request channel: reqcyc/reqack; response channel: respcyc/respack) between the instruction cache and the data cache.
- Grants one requester at a time, sequences address, write-data and read-response beats for one 64-byte line, and routes response beats back to the granted cache.
- Sits between the two cache instances and the top-level bus pins; exactly one transaction is in flight at a time.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp and of each beat
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
- BEATS, 8, beats per line (64 B / 8 B)
- LINE_OFFSET, 6, low address bits cleared to line-align

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ic_req  in  1  icache requests a line read
- ic_addr  in  64  icache miss address
- ic_grant  out  1  one-cycle pulse: icache request accepted
- ic_resp_valid  out  1  response beat valid for icache
- ic_resp_data  out  64  response beat
- ic_done  out  1  one-cycle pulse: last icache beat delivered
- dc_req  in  1  dcache requests a transaction
- dc_write  in  1  1 = line writeback, 0 = line read
- dc_addr  in  64  dcache address
- dc_wdata  in  64  current writeback beat
- dc_wdata_pop  out  1  pulse: current dc_wdata beat consumed, present next beat
- dc_grant  out  1  one-cycle pulse: dcache request accepted
- dc_resp_valid  out  1  response beat valid for dcache
- dc_resp_data  out  64  response beat
- dc_done  out  1  pulse: dcache transaction complete
- bus_reqcyc  out  1  request valid
- bus_reqack  in  1  memory accepted request beat
- bus_req  out  64  address or write beat
- bus_reqtag  out  13  MEM_READ or MEM_WRITE
- bus_respcyc  in  1  response beat valid
- bus_respack  out  1  response beat accepted
- bus_resp  in  64  response data
- bus_resptag  in  13  response tag
- tag_err  out  1  sticky: response beat carried an unexpected tag

Behaviour:
- Reset (reset==0 at posedge): state IDLE, all outputs 0, beat counter 0, rr pointer = icache (dcache wins the first tie). Reset mid-transaction abandons it; no done pulse is issued.
- FSM states: IDLE, ADDR, WDATA, RESP.
- IDLE:
  - Sample ic_req/dc_req and pick the winner by round-robin: on a tie, grant the requester not granted last; a single requester always wins.
  - Latch the owner, dc_write (forced 0 for icache) and the address with the low LINE_OFFSET bits cleared.
  - Pulse the grant for 1 cycle and go to ADDR.
  - Requester inputs are ignored after grant.
- ADDR:
  - bus_reqcyc=1, bus_req=aligned addr, bus_reqtag=MEM_WRITE if write else MEM_READ. Hold until bus_reqack.
  - On ack: go to WDATA if write, else RESP.
  - No earlier than the cycle after the ack, bus_reqcyc drops for at least 1 cycle before the next beat.
- WDATA:
  - bus_reqcyc=1, bus_req=dc_wdata, tag MEM_WRITE, per beat.
  - On each bus_reqack: pulse dc_wdata_pop and increment the counter.
  - On ack of beat BEATS-1: pulse dc_done, clear the counter, go to IDLE. Writes have no response phase.
- RESP:
  - bus_respack = bus_respcyc combinationally (every beat is acked in the same cycle).
  - Beat with bus_resptag==MEM_READ: drive the owner's resp_valid=1 and resp_data=bus_resp in that cycle (combinational pass-through), then increment the counter.
  - Beat BEATS-1: also pulse the owner's done in the same cycle, go to IDLE next cycle.
  - Beat with any other tag: acked, not counted, not forwarded, tag_err set (cleared only by reset).
  - The non-owner's resp_valid stays 0 at all times.
- Counter: 3 bits, wraps 7→0 on the last beat.
- No back-to-back overlap: a new grant can occur in the cycle after returning to IDLE at the earliest, i.e. 1 idle cycle between transactions.
- The rr pointer updates at grant time only.

Decomposition:
- Package mem_bus_pkg:
  - MEM_READ, MEM_WRITE tag constants
  - BEATS, LINE_OFFSET
  - enum arb_state_t {IDLE, ADDR, WDATA, RESP}
  - enum owner_t {OWN_IC, OWN_DC}
- Sub-module rr_arbiter2: 2-input round-robin picker with last-grant pointer. Combinational pick plus registered pointer, updated on an accept strobe.

Test Plan:
- Icache read alone, ic_addr=0x1234: ic_grant pulse; bus_req=0x1200 with tag MEM_READ held for 3 cycles until reqack; 8 respcyc beats 0..7 → 8 ic_resp_valid beats with data 0..7, bus_respack on each, ic_done on beat 7; dc_resp_valid stays 0.
- Dcache writeback, dc_addr=0x8040, data beats 0xA0..0xA7, reqack after 1 cycle each → address beat then 8 data beats with tag MEM_WRITE, 8 dc_wdata_pop pulses, dc_done on the last ack, no response phase.
- ic_req and dc_req high together from reset, each staying high → grants in order dc, ic, dc, ic (round-robin); 1 idle cycle between transactions.
- During an icache read, inject a beat with tag MEM_WRITE between beats 3 and 4 → beat acked, not forwarded, tag_err=1, still exactly 8 ic_resp_valid beats.
- Assert reset=0 after response beat 2 of a dcache read → next cycle all outputs 0, state IDLE, no dc_done; a fresh ic_req is granted first afterwards.
